// File: rtl/ras_pkg.sv
// Shared types and default sizing for the
// return-address stack controller.
package ras_pkg;

  localparam int RAS_DEPTH = 1024;
  localparam int RAS_WIDTH = 36;
  localparam int RAS_ADDR  = $clog2(RAS_DEPTH);
  localparam int CAPACITY  = RAS_DEPTH + 1;

  typedef logic [RAS_WIDTH-1:0] ras_addr_t;
  typedef logic [RAS_ADDR-1:0]  ras_ptr_t;
  typedef logic [RAS_ADDR:0]    ras_cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } ras_state_e;

endpackage

// File: rtl/ras_ctrl.sv
// Return-address stack controller: TOS held in a
// register, deeper entries spilled to a dual-port BRAM.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter  int DEPTH = RAS_DEPTH,
  parameter  int WIDTH = RAS_WIDTH,
  localparam int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] push_addr_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] top_o,
  output logic             top_valid_o,
  output logic [ADDR:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             ram_rea,
  output logic             ram_reb,
  output logic             ram_wea,
  output logic             ram_web,
  output logic [ADDR-1:0]  ram_raddra,
  output logic [ADDR-1:0]  ram_raddrb,
  output logic [ADDR-1:0]  ram_waddra,
  output logic [ADDR-1:0]  ram_waddrb,
  output logic [WIDTH-1:0] ram_wia,
  output logic [WIDTH-1:0] ram_wib,
  input  logic [WIDTH-1:0] ram_doa,
  input  logic [WIDTH-1:0] ram_dob
);

  localparam int CW = ADDR + 1;
  localparam logic [ADDR:0] CAP = CW'(DEPTH + 1);
  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

  ras_state_e       r_state;
  logic [ADDR-1:0]  r_ptr;
  logic [ADDR:0]    r_count;
  logic [WIDTH-1:0] r_tos;
  logic             r_ovf;
  logic             r_unf;

  ras_state_e       w_nxt_state;
  logic [ADDR-1:0]  w_nxt_ptr;
  logic [ADDR:0]    w_nxt_count;
  logic [WIDTH-1:0] w_nxt_tos;
  logic             w_nxt_ovf;
  logic             w_nxt_unf;

  logic             w_idle;
  logic             w_fill;
  logic             w_both;
  logic             w_push;
  logic             w_pop;
  logic             w_wea;
  logic             w_reb;
  logic [ADDR-1:0]  w_ptr_inc;
  logic [ADDR-1:0]  w_ptr_dec;
  logic             w_unused;

  // Port A of the BRAM is write-only, so its read data is dead.
  assign w_unused = ^ram_doa;

  // Mutually exclusive request decode; flush dominates.
  assign w_idle = (r_state == IDLE);
  assign w_fill = !flush_i && (r_state == FILL);
  assign w_both = !flush_i && w_idle && push_i && pop_i;
  assign w_push = !flush_i && w_idle && push_i && !pop_i;
  assign w_pop  = !flush_i && w_idle && !push_i && pop_i;

  assign w_ptr_inc = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
  assign w_ptr_dec = (r_ptr == '0) ? LAST : r_ptr - 1'b1;

  assign w_wea = w_push && (r_count != '0);
  assign w_reb = w_pop && (r_count >= CW'(2));

  assign ram_rea    = 1'b0;
  assign ram_web    = 1'b0;
  assign ram_raddra = '0;
  assign ram_waddrb = '0;
  assign ram_wib    = '0;
  assign ram_wea    = w_wea;
  assign ram_waddra = w_wea ? r_ptr : '0;
  assign ram_wia    = w_wea ? r_tos : '0;
  assign ram_reb    = w_reb;
  assign ram_raddrb = w_reb ? w_ptr_dec : '0;

  assign ready_o     = w_idle;
  assign top_valid_o = w_idle && (r_count != '0);
  assign top_o       = r_tos;
  assign count_o     = r_count;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_unf;

  // Next-state and stack bookkeeping for one accepted request.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_count = r_count;
    w_nxt_tos   = r_tos;
    w_nxt_ovf   = 1'b0;
    w_nxt_unf   = 1'b0;
    unique case (1'b1)
      flush_i: begin
        w_nxt_state = IDLE;
        w_nxt_ptr   = '0;
        w_nxt_count = '0;
      end
      w_fill: begin
        w_nxt_tos   = ram_dob;
        w_nxt_state = IDLE;
      end
      w_both: begin
        w_nxt_tos = push_addr_i;
        if (r_count == '0)
          w_nxt_count = CW'(1);
      end
      w_push: begin
        w_nxt_tos = push_addr_i;
        if (r_count != '0)
          w_nxt_ptr = w_ptr_inc;
        if (r_count == CAP)
          w_nxt_ovf = 1'b1;
        else
          w_nxt_count = r_count + 1'b1;
      end
      w_pop: begin
        if (r_count == '0) begin
          w_nxt_unf = 1'b1;
        end else if (r_count == CW'(1)) begin
          w_nxt_count = '0;
        end else begin
          w_nxt_ptr   = w_ptr_dec;
          w_nxt_count = r_count - 1'b1;
          w_nxt_state = FILL;
        end
      end
      default: ;
    endcase
  end

  // Stack state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_tos   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ptr   <= w_nxt_ptr;
      r_count <= w_nxt_count;
      r_tos   <= w_nxt_tos;
      r_ovf   <= w_nxt_ovf;
      r_unf   <= w_nxt_unf;
    end
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl with a small behavioural BRAM and
// a queue-based stack reference model.
module tb_ras_ctrl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 36;
  localparam int ADDR  = $clog2(DEPTH);
  localparam int CAP   = DEPTH + 1;

  logic             clk;
  logic             rst_n;
  logic             push_i;
  logic             pop_i;
  logic             flush_i;
  logic [WIDTH-1:0] push_addr_i;
  logic             ready_o;
  logic [WIDTH-1:0] top_o;
  logic             top_valid_o;
  logic [ADDR:0]    count_o;
  logic             overflow_o;
  logic             underflow_o;
  logic             ram_rea;
  logic             ram_reb;
  logic             ram_wea;
  logic             ram_web;
  logic [ADDR-1:0]  ram_raddra;
  logic [ADDR-1:0]  ram_raddrb;
  logic [ADDR-1:0]  ram_waddra;
  logic [ADDR-1:0]  ram_waddrb;
  logic [WIDTH-1:0] ram_wia;
  logic [WIDTH-1:0] ram_wib;
  logic [WIDTH-1:0] ram_doa;
  logic [WIDTH-1:0] ram_dob;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] m_tos;
  logic             m_fill;
  logic             m_ovf;
  logic             m_unf;

  int n_chk;
  int n_pass;

  ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_i(push_i), .pop_i(pop_i), .flush_i(flush_i),
    .push_addr_i(push_addr_i),
    .ready_o(ready_o), .top_o(top_o),
    .top_valid_o(top_valid_o), .count_o(count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .ram_rea(ram_rea), .ram_reb(ram_reb),
    .ram_wea(ram_wea), .ram_web(ram_web),
    .ram_raddra(ram_raddra), .ram_raddrb(ram_raddrb),
    .ram_waddra(ram_waddra), .ram_waddrb(ram_waddrb),
    .ram_wia(ram_wia), .ram_wib(ram_wib),
    .ram_doa(ram_doa), .ram_dob(ram_dob)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stack BRAM: A write-only, B read-only, 1-cycle read.
  always @(posedge clk) begin
    ram_doa <= '0;
    if (ram_wea) mem[ram_waddra] <= ram_wia;
    if (ram_reb) ram_dob <= mem[ram_raddrb];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic post_chk();
    chk("ready", 64'(ready_o), 64'(!m_fill));
    chk("tvalid", 64'(top_valid_o),
        64'(!m_fill && q.size() != 0));
    chk("count", 64'(count_o), 64'(q.size()));
    chk("top", 64'(top_o), 64'(m_tos));
    chk("ovf", 64'(overflow_o), 64'(m_ovf));
    chk("unf", 64'(underflow_o), 64'(m_unf));
  endtask

  task automatic step(input logic ps, input logic pp,
                      input logic fl,
                      input logic [WIDTH-1:0] a);
    logic busy;
    logic e_wea;
    logic e_reb;
    int   n;
    @(negedge clk);
    push_i = ps;
    pop_i = pp;
    flush_i = fl;
    push_addr_i = a;
    #1;
    busy = m_fill;
    n = q.size();
    e_wea = !fl && !busy && ps && !pp && n > 0;
    e_reb = !fl && !busy && pp && !ps && n >= 2;
    chk("wea", 64'(ram_wea), 64'(e_wea));
    chk("reb", 64'(ram_reb), 64'(e_reb));
    chk("rea", 64'(ram_rea), 64'(0));
    chk("web", 64'(ram_web), 64'(0));
    if (e_wea) chk("wia", 64'(ram_wia), 64'(m_tos));
    @(posedge clk);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (fl) begin
      q.delete();
      m_fill = 1'b0;
    end else if (busy) begin
      m_fill = 1'b0;
      m_tos = q[$];
    end else if (ps && pp) begin
      if (n == 0) q.push_back(a);
      else q[$] = a;
      m_tos = a;
    end else if (ps) begin
      q.push_back(a);
      if (q.size() > CAP) begin
        void'(q.pop_front());
        m_ovf = 1'b1;
      end
      m_tos = a;
    end else if (pp) begin
      if (n == 0) m_unf = 1'b1;
      else begin
        void'(q.pop_back());
        if (q.size() > 0) m_fill = 1'b1;
      end
    end
    #1;
    post_chk();
  endtask

  task automatic do_pop();
    step(1'b0, 1'b1, 1'b0, '0);
    if (m_fill) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic reset_model();
    q.delete();
    m_tos = '0;
    m_fill = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_pop [4];
  logic [WIDTH-1:0] ra;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    push_i = 1'b0;
    pop_i = 1'b0;
    flush_i = 1'b0;
    push_addr_i = '0;
    reset_model();
    #12;
    post_chk();
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 1'b0, 1'b0, 36'h100);
    step(1'b1, 1'b0, 1'b0, 36'h200);
    step(1'b1, 1'b0, 1'b0, 36'h300);
    chk("t1_top", 64'(top_o), 64'h300);
    chk("t1_cnt", 64'(count_o), 64'd3);
    chk("t1_m0", 64'(mem[0]), 64'h100);
    chk("t1_m1", 64'(mem[1]), 64'h200);

    step(1'b0, 1'b1, 1'b0, '0);
    chk("t2_rdy", 64'(ready_o), 64'd0);
    chk("t2_tv", 64'(top_valid_o), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("t2_top", 64'(top_o), 64'h200);
    chk("t2_cnt", 64'(count_o), 64'd2);

    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, 1'b0, WIDTH'(i));
      chk("t3_ovf", 64'(overflow_o), 64'(i == 6));
    end
    chk("t3_cnt", 64'(count_o), 64'd5);
    chk("t3_top", 64'(top_o), 64'h6);
    exp_pop[0] = 36'h5;
    exp_pop[1] = 36'h4;
    exp_pop[2] = 36'h3;
    exp_pop[3] = 36'h2;
    for (int i = 0; i < 4; i++) begin
      do_pop();
      chk("t3_pop", 64'(top_o), 64'(exp_pop[i]));
    end
    do_pop();
    chk("t3_c0", 64'(count_o), 64'd0);
    do_pop();
    chk("t3_unf", 64'(underflow_o), 64'd1);

    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 36'h9);
    step(1'b1, 1'b0, 1'b0, 36'hA);
    step(1'b1, 1'b1, 1'b0, 36'hB);
    chk("t4_top", 64'(top_o), 64'hB);
    chk("t4_cnt", 64'(count_o), 64'd2);

    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("t5_unf", 64'(underflow_o), 64'd1);
    chk("t5_cnt", 64'(count_o), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("t5_unf0", 64'(underflow_o), 64'd0);

    step(1'b1, 1'b0, 1'b0, 36'h1);
    step(1'b1, 1'b0, 1'b0, 36'h2);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("t6_cnt", 64'(count_o), 64'd0);
    chk("t6_rdy", 64'(ready_o), 64'd1);
    step(1'b1, 1'b0, 1'b0, 36'h7);
    chk("t6_top", 64'(top_o), 64'h7);
    chk("t6_cnt1", 64'(count_o), 64'd1);

    for (int i = 0; i < 800; i++) begin
      ra = {4'($urandom_range(15, 0)), $urandom};
      step(1'($urandom_range(1, 0)),
           1'($urandom_range(1, 0)),
           1'($urandom_range(31, 0) == 0), ra);
    end

    step(1'b1, 1'b0, 1'b0, 36'h55);
    step(1'b1, 1'b0, 1'b0, 36'h66);
    step(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    push_i = 1'b0;
    pop_i = 1'b0;
    flush_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    post_chk();
    chk("rst_wea", 64'(ram_wea), 64'd0);
    chk("rst_reb", 64'(ram_reb), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 36'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Stack controller for the return-address stack (RAS). It sits directly upstream of the dual-port stack BRAM and drives all of that BRAM's ports.
- It accepts call (push) and return (pop) requests from the fetch stage and keeps the top-of-stack (TOS) in a register for zero-latency prediction.
- Entries below TOS spill to the BRAM and refill from it; the BRAM has 1-cycle read latency.

Parameters:
- DEPTH, 1024, number of BRAM entries; total capacity is DEPTH+1 (BRAM plus TOS register).
- WIDTH, 36, return-address width.
- ADDR, $clog2(DEPTH), localparam, BRAM address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- push_i  in  1  call: push push_addr_i
- pop_i  in  1  return: pop TOS
- flush_i  in  1  synchronous clear of the stack
- push_addr_i  in  WIDTH  return address to push
- ready_o  out  1  push/pop accepted this cycle
- top_o  out  WIDTH  current TOS
- top_valid_o  out  1  top_o is valid
- count_o  out  ADDR+1  number of live entries, 0..DEPTH+1
- overflow_o  out  1  1-cycle pulse: oldest entry lost
- underflow_o  out  1  1-cycle pulse: pop while empty
- ram_rea, ram_reb, ram_wea, ram_web  out  1  BRAM port enables
- ram_raddra, ram_raddrb, ram_waddra, ram_waddrb  out  ADDR  BRAM addresses
- ram_wia, ram_wib  out  WIDTH  BRAM write data
- ram_doa, ram_dob  in  WIDTH  BRAM read data (valid 1 cycle after the read enable)

Behaviour:
- Reset (async, rst_n=0) sets the following:
  - ptr=0, count=0, tos=0, state=IDLE.
  - top_valid_o=0, overflow_o=0, underflow_o=0, ready_o=1.
- BRAM port usage:
  - Port A is write-only (ram_rea=0). Port B is read-only (ram_web=0).
  - Unused address and data outputs are tied to 0.
  - Port A and port B are never active in the same cycle, so the BRAM needs no collision resolution.
- State:
  - ptr is the next free BRAM slot, mod DEPTH.
  - States are IDLE and FILL.
  - ready_o = (state==IDLE).
  - top_valid_o = (state==IDLE) && count!=0.
  - top_o = tos (registered).
- Push only, in IDLE:
  - If count>0: ram_wea=1, ram_waddra=ptr, ram_wia=tos, ptr<=ptr+1 (wraps DEPTH-1 to 0).
  - tos<=push_addr_i.
  - count<=count+1, saturating at DEPTH+1.
  - A push at count==DEPTH+1 still writes, silently overwriting the oldest entry, and pulses overflow_o.
- Pop only, in IDLE:
  - count>=2: ram_reb=1, ram_raddrb=ptr-1 (wraps), ptr<=ptr-1, count<=count-1, state<=FILL.
  - count==1: count<=0, no BRAM access.
  - count==0: no state change, underflow_o pulses.
- FILL (exactly 1 cycle): tos<=ram_dob, state<=IDLE.
  - ready_o=0 in FILL. Push and pop are ignored; the requester holds the request until ready_o=1.
- Push and pop together, in IDLE (call and return in the same cycle):
  - tos<=push_addr_i, no BRAM access, ptr unchanged.
  - count is unchanged, except count 0 becomes 1.
  - No underflow pulse.
- Flush:
  - Highest priority, accepted in any state.
  - Next cycle: count=0, ptr=0, state=IDLE, tos unchanged.
  - An in-flight FILL is abandoned and ram_dob is ignored.
  - Any push/pop in the same cycle is dropped, and no BRAM enable is asserted that cycle.
- Wrap-around: after an overflow, count caps the number of pops that read valid data. Pops beyond the capacity follow the underflow rule.

Decomposition:
- Package ras_pkg holds:
  - typedef ras_state_e {IDLE, FILL}
  - ras_addr_t / ras_ptr_t widths derived from DEPTH/WIDTH
  - localparam CAPACITY = DEPTH+1
- No sub-module. ras_ctrl and the BRAM are peers connected in the RAS top.
- The bench instantiates ras_ctrl with the stack BRAM (RESOLVE_COLLIDE=0).

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 -> top_o=0x300, count_o=3. BRAM writes 0x100@0 and 0x200@1, ptr=2.
- From that state, pop -> next cycle ready_o=0, top_valid_o=0. The cycle after: top_o=0x200, count_o=2, ready_o=1.
- DEPTH=4: push 0x1..0x6 -> overflow_o pulses exactly once, on the 6th push. count_o=5, top_o=0x6. Then pop x5 yields TOS 0x5, 0x4, 0x3, 0x2, then count 0. A 6th pop pulses underflow_o.
- Push+pop in the same cycle with TOS=0xA, count=2, push_addr_i=0xB -> top_o=0xB, count_o=2, no BRAM enable asserted.
- Pop with count 0 -> underflow_o high for 1 cycle, count_o stays 0, top_valid_o=0.
- Flush in the FILL cycle -> next cycle count_o=0, ready_o=1, top_valid_o=0. Then push 0x7 -> top_o=0x7, count_o=1, no BRAM write. Assert rst_n low mid-stream -> all outputs return to reset values immediately (asynchronously).
